// File: rtl/eth_tx_frame_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : eth_tx_frame_arbiter_if
// Brief    : Source-side byte lanes and granted TX byte stream of the arbiter.
// Revision : 1.0
// ============================================================================
interface eth_tx_frame_arbiter_if #(
    parameter int N_SRC = 2
);
    logic [8*N_SRC-1:0] src_data;
    logic [N_SRC-1:0]   src_valid;
    logic [N_SRC-1:0]   src_last;
    logic [N_SRC-1:0]   src_ready;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_last;
    logic               tx_ready;

    // Environment side: frame sources plus the downstream TX sink.
    modport master (
        output src_data, src_valid, src_last, tx_ready,
        input  src_ready, tx_data, tx_valid, tx_last
    );

    // Arbiter side.
    modport slave (
        input  src_data, src_valid, src_last, tx_ready,
        output src_ready, tx_data, tx_valid, tx_last
    );
endinterface
`default_nettype wire

// File: rtl/eth_tx_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : eth_tx_frame_arbiter
// Brief    : Round-robin whole-frame arbiter onto one TX byte stream with
//            inter-frame gap and oversize truncate/drain.
// Revision : 1.0
// ============================================================================
module eth_tx_frame_arbiter #(
    parameter int N_SRC           = 2,
    parameter int IFG_CYCLES      = 12,
    parameter int MAX_FRAME_BYTES = 1514,
    localparam int C_GW           = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  wire                   clk125,
    input  wire                   rst_n,
    eth_tx_frame_arbiter_if.slave bus,
    output logic [C_GW-1:0]       grant_id,
    output logic                  busy,
    output logic                  err_oversize
);
    localparam int C_CW  = $clog2(MAX_FRAME_BYTES + 1);
    localparam int C_GCW = (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;

    localparam logic [1:0] C_ST_IDLE  = 2'd0;
    localparam logic [1:0] C_ST_XFER  = 2'd1;
    localparam logic [1:0] C_ST_DRAIN = 2'd2;
    localparam logic [1:0] C_ST_GAP   = 2'd3;
    // With no gap configured, a finished frame returns straight to arbitration.
    localparam logic [1:0] C_ST_POST  = (IFG_CYCLES == 0) ? C_ST_IDLE : C_ST_GAP;

    localparam logic [C_CW-1:0]  C_CNT_LAST  = C_CW'(MAX_FRAME_BYTES - 1);
    localparam logic [C_GCW-1:0] C_GAP_LAST  = C_GCW'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
    localparam logic [C_GW-1:0]  C_GRANT_MAX = C_GW'(N_SRC - 1);

    logic [1:0]       r_state;
    logic [C_GW-1:0]  r_grant;
    logic [C_GW-1:0]  r_rr_ptr;
    logic [C_CW-1:0]  r_byte_cnt;
    logic [C_GCW-1:0] r_gap_cnt;
    logic             r_err;

    logic [7:0]       w_sel_data;
    logic             w_sel_valid;
    logic             w_sel_last;
    logic [N_SRC-1:0] w_grant_onehot;
    logic [C_GW-1:0]  w_pick;
    logic             w_pick_hit;
    logic [C_GW-1:0]  w_rr_next;
    logic             w_beat;
    logic             w_forced;

    assign grant_id     = r_grant;
    assign busy         = (r_state != C_ST_IDLE);
    assign err_oversize = r_err;

    always_comb begin
        w_sel_data     = '0;
        w_sel_valid    = 1'b0;
        w_sel_last     = 1'b0;
        w_grant_onehot = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (r_grant == C_GW'(k)) begin
                w_sel_data        = bus.src_data[8*k +: 8];
                w_sel_valid       = bus.src_valid[k];
                w_sel_last        = bus.src_last[k];
                w_grant_onehot[k] = 1'b1;
            end
        end
    end

    // Lowest valid index at or above rr_ptr wins; otherwise wrap to the lowest valid.
    always_comb begin
        w_pick     = '0;
        w_pick_hit = 1'b0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (bus.src_valid[k]) begin
                w_pick     = C_GW'(k);
                w_pick_hit = 1'b1;
            end
        end
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (bus.src_valid[k] && (C_GW'(k) >= r_rr_ptr)) begin
                w_pick = C_GW'(k);
            end
        end
    end

    assign w_rr_next = (r_grant == C_GRANT_MAX) ? '0 : r_grant + C_GW'(1);
    assign w_beat    = w_sel_valid && bus.tx_ready;
    assign w_forced  = (r_byte_cnt == C_CNT_LAST);

    always_comb begin
        bus.tx_data   = '0;
        bus.tx_valid  = 1'b0;
        bus.tx_last   = 1'b0;
        bus.src_ready = '0;
        case (r_state)
            C_ST_XFER: begin
                bus.tx_data   = w_sel_data;
                bus.tx_valid  = w_sel_valid;
                bus.tx_last   = w_sel_last | w_forced;
                bus.src_ready = w_grant_onehot & {N_SRC{bus.tx_ready}};
            end
            C_ST_DRAIN: begin
                bus.src_ready = w_grant_onehot;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk125 or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= C_ST_IDLE;
            r_grant    <= '0;
            r_rr_ptr   <= '0;
            r_byte_cnt <= '0;
            r_gap_cnt  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                C_ST_IDLE: begin
                    if (w_pick_hit) begin
                        r_grant    <= w_pick;
                        r_byte_cnt <= '0;
                        r_state    <= C_ST_XFER;
                    end
                end
                C_ST_XFER: begin
                    if (w_beat) begin
                        r_byte_cnt <= r_byte_cnt + C_CW'(1);
                        if (w_sel_last) begin
                            r_rr_ptr  <= w_rr_next;
                            r_gap_cnt <= '0;
                            r_state   <= C_ST_POST;
                        end else if (w_forced) begin
                            // Truncated here; the rest of the frame is swallowed in DRAIN.
                            r_err    <= 1'b1;
                            r_rr_ptr <= w_rr_next;
                            r_state  <= C_ST_DRAIN;
                        end
                    end
                end
                C_ST_DRAIN: begin
                    if (w_sel_valid && w_sel_last) begin
                        r_gap_cnt <= '0;
                        r_state   <= C_ST_POST;
                    end
                end
                C_ST_GAP: begin
                    if (r_gap_cnt == C_GAP_LAST) begin
                        r_state <= C_ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + C_GCW'(1);
                    end
                end
                default: r_state <= C_ST_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_eth_tx_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_tx_frame_arbiter
// Brief    : Scoreboard bench: frame-level round-robin model vs. arbiter output.
// Revision : 1.0
// ============================================================================
module tb_eth_tx_frame_arbiter;
    localparam int N        = 2;
    localparam int IFG      = 12;
    localparam int MAXB     = 1514;
    localparam int N2_BYTES = 40;

    typedef struct {
        int         src;
        logic [7:0] data;
        bit         last;
        bit         trunc;
    } exp_t;

    logic clk125 = 1'b0;
    logic rst_n  = 1'b0;
    logic rst2_n = 1'b0;
    always #4 clk125 = ~clk125;

    eth_tx_frame_arbiter_if #(.N_SRC(N)) bus ();
    eth_tx_frame_arbiter_if #(.N_SRC(1)) bus2 ();

    logic [0:0] grant_id;
    logic       busy;
    logic       err_oversize;
    logic [0:0] grant_id2;
    logic       busy2;
    logic       err2;

    eth_tx_frame_arbiter #(.N_SRC(N), .IFG_CYCLES(IFG), .MAX_FRAME_BYTES(MAXB)) dut (
        .clk125(clk125), .rst_n(rst_n), .bus(bus),
        .grant_id(grant_id), .busy(busy), .err_oversize(err_oversize)
    );

    eth_tx_frame_arbiter #(.N_SRC(1), .IFG_CYCLES(0), .MAX_FRAME_BYTES(4)) dut2 (
        .clk125(clk125), .rst_n(rst2_n), .bus(bus2),
        .grant_id(grant_id2), .busy(busy2), .err_oversize(err2)
    );

    int         errors = 0;
    int         checks = 0;

    exp_t       exp_q[$];
    logic [8:0] drv_q[N][$];
    logic [7:0] frm_bytes[N][$];
    int         frm_len[N][$];
    int         model_rr = 0;

    int         stall_left[N];
    int         bcnt[N];
    bit         in_frame[N];
    int         gap_pct = 0;
    int         ready_mode = 0;
    logic [N-1:0] hs;

    int  cyc = 0;
    int  last_cyc = 0;
    bit  have_last = 0;
    bit  first_beat = 1;
    bit  exact_gap = 0;
    bit  exp_err_next = 0;

    logic [8:0] exp2_q[$];
    int  sent2 = 0;
    bit  hs2;
    int  cyc2 = 0;
    int  last2 = 0;
    bit  seen2 = 0;
    bit  first2 = 1;
    bit  after_last2 = 0;

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic add_frame(input int k, input int len);
        logic [7:0] b;
        frm_len[k].push_back(len);
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            drv_q[k].push_back({(i == len - 1), b});
            frm_bytes[k].push_back(b);
        end
    endtask

    // Frame-level model: pending frames are granted round-robin, each emitted
    // whole (or cut to MAXB bytes with the last flag moved onto the cut).
    task automatic model_run();
        int pick;
        int len;
        int n;
        exp_t e;
        logic [7:0] b;
        forever begin
            pick = -1;
            for (int o = 0; o < N; o++) begin
                if (pick < 0 && frm_len[(model_rr + o) % N].size() > 0) pick = (model_rr + o) % N;
            end
            if (pick < 0) break;
            len = frm_len[pick].pop_front();
            n   = (len > MAXB) ? MAXB : len;
            for (int i = 0; i < len; i++) begin
                b = frm_bytes[pick].pop_front();
                if (i < n) begin
                    e.src   = pick;
                    e.data  = b;
                    e.last  = (i == n - 1);
                    e.trunc = (len > MAXB);
                    exp_q.push_back(e);
                end
            end
            model_rr = (pick + 1) % N;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (n < budget && (exp_q.size() != 0 || drv_q[0].size() != 0 ||
                              drv_q[1].size() != 0 || busy)) begin
            @(negedge clk125);
            n++;
        end
        check(n < budget, "phase_timeout", n, budget);
        repeat (2) @(negedge clk125);
    endtask

    // Source and sink driver for the main arbiter.
    initial begin
        bus.src_valid = '0;
        bus.src_data  = '0;
        bus.src_last  = '0;
        bus.tx_ready  = 1'b0;
        forever begin
            @(negedge clk125);
            hs = bus.src_valid & bus.src_ready;
            @(posedge clk125);
            #1;
            if (!rst_n) begin
                bus.src_valid = '0;
                bus.tx_ready  = 1'b0;
                continue;
            end
            for (int k = 0; k < N; k++) begin
                if (hs[k] && drv_q[k].size() > 0) begin
                    in_frame[k] = !drv_q[k][0][8];
                    bcnt[k]     = in_frame[k] ? bcnt[k] + 1 : 0;
                    void'(drv_q[k].pop_front());
                end
                if (drv_q[k].size() == 0) begin
                    bus.src_valid[k] = 1'b0;
                end else if (in_frame[k] && bcnt[k] == 10 && stall_left[k] > 0) begin
                    bus.src_valid[k] = 1'b0;
                    stall_left[k]--;
                end else if (in_frame[k] && $urandom_range(0, 99) < gap_pct) begin
                    bus.src_valid[k] = 1'b0;
                end else begin
                    bus.src_valid[k] = 1'b1;
                end
                bus.src_data[8*k +: 8] = (drv_q[k].size() > 0) ? drv_q[k][0][7:0] : 8'h00;
                bus.src_last[k]        = (drv_q[k].size() > 0) ? drv_q[k][0][8] : 1'b0;
            end
            case (ready_mode)
                0:       bus.tx_ready = 1'b1;
                1:       bus.tx_ready = ~bus.tx_ready;
                default: bus.tx_ready = ($urandom_range(0, 99) < 70);
            endcase
        end
    end

    // Monitor for the main arbiter.
    initial begin
        exp_t e;
        int   gap;
        forever begin
            @(negedge clk125);
            cyc++;
            if (!rst_n) continue;
            check(err_oversize == exp_err_next, "err_oversize", err_oversize, exp_err_next);
            exp_err_next = 0;
            for (int k = 0; k < N; k++) begin
                if (bus.src_ready[k] && int'(grant_id) != k)
                    check(0, "src_ready_not_granted", k, grant_id);
            end
            if (bus.tx_valid && bus.tx_ready) begin
                if (exp_q.size() == 0) begin
                    check(0, "unexpected_beat", bus.tx_data, -1);
                end else begin
                    e = exp_q.pop_front();
                    check(bus.tx_data == e.data, "tx_data", bus.tx_data, e.data);
                    check(bus.tx_last == e.last, "tx_last", bus.tx_last, e.last);
                    check(int'(grant_id) == e.src, "grant_id", grant_id, e.src);
                    if (first_beat && have_last) begin
                        gap = cyc - last_cyc;
                        check(exact_gap ? (gap == IFG + 2) : (gap >= IFG + 2), "ifg_spacing", gap, IFG + 2);
                    end
                    first_beat = e.last;
                    if (e.last) begin
                        last_cyc     = cyc;
                        have_last    = 1;
                        exp_err_next = e.trunc;
                    end
                end
            end
        end
    end

    // Single-source, zero-gap arbiter: back-to-back 2-byte frames.
    initial begin
        bus2.src_valid = '0;
        bus2.src_data  = '0;
        bus2.src_last  = '0;
        bus2.tx_ready  = 1'b1;
        for (int i = 0; i < N2_BYTES; i++) exp2_q.push_back({(i % 2 == 1), 8'(i)});
        forever begin
            @(negedge clk125);
            hs2 = bus2.src_valid[0] & bus2.src_ready[0];
            @(posedge clk125);
            #1;
            if (!rst2_n) continue;
            if (hs2) sent2++;
            bus2.src_valid[0] = (sent2 < N2_BYTES);
            bus2.src_data     = 8'(sent2);
            bus2.src_last[0]  = (sent2 % 2 == 1);
        end
    end

    initial begin
        logic [8:0] e2;
        forever begin
            @(negedge clk125);
            if (!rst2_n) continue;
            cyc2++;
            if (after_last2) check(!busy2, "ifg0_idle_between", busy2, 0);
            after_last2 = 0;
            if (bus2.tx_valid && bus2.tx_ready) begin
                if (exp2_q.size() == 0) begin
                    check(0, "ifg0_unexpected_beat", bus2.tx_data, -1);
                end else begin
                    e2 = exp2_q.pop_front();
                    check(bus2.tx_data == e2[7:0], "ifg0_data", bus2.tx_data, e2[7:0]);
                    check(bus2.tx_last == e2[8], "ifg0_last", bus2.tx_last, e2[8]);
                    check(grant_id2 == 1'b0 && !err2, "ifg0_grant_err", {grant_id2, err2}, 0);
                    if (first2 && seen2) check(cyc2 - last2 == 2, "ifg0_spacing", cyc2 - last2, 2);
                    first2 = e2[8];
                    if (e2[8]) begin
                        last2       = cyc2;
                        seen2       = 1;
                        after_last2 = 1;
                    end
                end
            end
        end
    end

    initial begin
        int n;
        for (int k = 0; k < N; k++) begin
            stall_left[k] = 0;
            bcnt[k]       = 0;
            in_frame[k]   = 0;
        end
        repeat (3) @(negedge clk125);
        check(bus.tx_valid == 0 && bus.tx_last == 0, "reset_tx", {bus.tx_valid, bus.tx_last}, 0);
        check(bus.src_ready == '0, "reset_src_ready", bus.src_ready, 0);
        check(busy == 0 && err_oversize == 0, "reset_busy_err", {busy, err_oversize}, 0);
        check(grant_id == 0, "reset_grant", grant_id, 0);
        rst_n  = 1'b1;
        rst2_n = 1'b1;
        @(negedge clk125);

        // Fairness: three 64-byte frames per source, exact gap spacing.
        exact_gap = 1;
        have_last = 0;
        for (int f = 0; f < 3; f++) begin
            add_frame(0, 64);
            add_frame(1, 64);
        end
        model_run();
        wait_idle(3000);
        exact_gap = 0;

        // Backpressure 1010 on a 60-byte frame from src1.
        have_last  = 0;
        ready_mode = 1;
        add_frame(1, 60);
        model_run();
        wait_idle(1000);
        ready_mode = 0;

        // Oversize, exact-size and one-over frames.
        have_last = 0;
        add_frame(0, 1600);
        model_run();
        wait_idle(4000);
        add_frame(0, MAXB);
        model_run();
        wait_idle(4000);
        add_frame(1, MAXB + 1);
        model_run();
        wait_idle(4000);

        // src1 stalls 5 cycles mid-frame while src0 keeps requesting.
        have_last     = 0;
        stall_left[1] = 5;
        add_frame(0, 40);
        add_frame(0, 40);
        add_frame(1, 40);
        model_run();
        wait_idle(2000);
        check(stall_left[1] == 0, "stall_applied", stall_left[1], 0);

        // Leave rr_ptr at 1, then reset in the middle of a src0 frame.
        have_last = 0;
        add_frame(0, 30);
        model_run();
        wait_idle(1000);
        have_last = 0;
        add_frame(0, 200);
        model_run();
        repeat (30) @(negedge clk125);
        check(busy && bus.tx_valid, "pre_reset_xfer", {busy, bus.tx_valid}, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check(bus.tx_valid == 0 && bus.tx_last == 0, "async_reset_tx", {bus.tx_valid, bus.tx_last}, 0);
        check(bus.src_ready == '0, "async_reset_src_ready", bus.src_ready, 0);
        check(busy == 0 && grant_id == 0, "async_reset_busy_grant", {busy, grant_id}, 0);
        exp_q.delete();
        for (int k = 0; k < N; k++) begin
            drv_q[k].delete();
            frm_bytes[k].delete();
            frm_len[k].delete();
            in_frame[k] = 0;
            bcnt[k]     = 0;
        end
        model_rr     = 0;
        first_beat   = 1;
        have_last    = 0;
        exp_err_next = 0;
        repeat (2) @(negedge clk125);
        rst_n = 1'b1;
        add_frame(1, 20);
        add_frame(0, 20);
        model_run();
        wait_idle(1000);

        // Randomized traffic: valid gaps, random ready, mixed lengths.
        gap_pct    = 20;
        ready_mode = 2;
        for (int r = 0; r < 6; r++) begin
            have_last = 0;
            for (int k = 0; k < N; k++) begin
                int nf = $urandom_range(1, 3);
                for (int f = 0; f < nf; f++) add_frame(k, $urandom_range(1, 100));
            end
            model_run();
            wait_idle(6000);
        end
        gap_pct    = 0;
        ready_mode = 0;

        n = 0;
        while (exp2_q.size() != 0 && n < 1000) begin
            @(negedge clk125);
            n++;
        end
        check(n < 1000, "ifg0_timeout", n, 1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
